nand_cmd_sequencer: RTL and testbench
=====================================

Name: nand_cmd_sequencer

Overview:
Host-side command sequencer directly upstream of nand_master. It turns one `start` pulse into the fixed command/activate/busy sequence nand_master needs. Two operations are supported: an init + ID probe, and a page read streamed out byte-by-byte. It replaces the hand-driven cmd_in/activate sequences currently applied by the bench and by software.

Parameters:
PAGE_BYTES, 4320, bytes streamed per page read (1..65535)
ID_BYTES, 5, ID bytes captured by the probe (1..8)
TIMEOUT, 1000000, max cycles waiting for nm_busy low per command before error
GAP_CYCLES, 1, idle cycles between the end of nm_busy and the next activate (0..15)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; ignored unless idle
op  in  1  0 = init/ID probe, 1 = page read stream; sampled with start
ce_sel  in  8  chip-enable selector, passed as data_in of MI_CHIP_ENABLE
id_out  out  64  captured ID bytes, byte k in bits [8k+7:8k], unused bytes 0
id_valid  out  1  high once a probe completes; cleared by the next start
byte_data  out  8  page byte stream data
byte_valid  out  1  stream valid
byte_ready  in  1  stream ready
seq_busy  out  1  high from the cycle after an accepted start until done/error
done  out  1  one-cycle pulse at successful completion
error  out  1  one-cycle pulse on timeout; sequence aborted
nm_cmd_in  out  6  to nand_master cmd_in
nm_activate  out  1  to nand_master activate
nm_data_in  out  8  to nand_master data_in
nm_data_out  in  8  from nand_master data_out
nm_busy  in  1  from nand_master busy

Behaviour:
- Reset values: all outputs 0; nm_cmd_in=0; FSM in IDLE; counters 0.
- Command codes: M_RESET 0x01, M_NAND_RESET 0x04, M_NAND_READ_ID 0x06, M_NAND_READ 0x09, MI_CHIP_ENABLE 0x0E, MI_RESET_INDEX 0x12, MI_GET_ID_BYTE 0x13, MI_GET_DATA_PAGE_BYTE 0x15.
- Command script:
  - op=0: M_RESET, MI_CHIP_ENABLE (data_in=ce_sel), M_NAND_RESET, M_NAND_READ_ID (data_in=0x00), then ID_BYTES × MI_GET_ID_BYTE.
  - op=1: MI_RESET_INDEX, M_NAND_READ, MI_RESET_INDEX, then PAGE_BYTES × MI_GET_DATA_PAGE_BYTE.
- FSM states: IDLE -> ISSUE -> ARM -> WAIT -> (CAPTURE | STREAM) -> GAP -> ISSUE ... -> FIN -> IDLE; any WAIT may go to ERR -> IDLE.
- IDLE: on start=1, latch op and ce_sel, clear id_out/id_valid, go to ISSUE.
- ISSUE: drive nm_cmd_in/nm_data_in; assert nm_activate for exactly 1 cycle. cmd and data stay stable from ISSUE until the next ISSUE.
- ARM: one cycle that ignores nm_busy, covering the master's busy-rise latency.
- WAIT: count cycles while nm_busy=1. If the count reaches TIMEOUT, go to ERR. When nm_busy=0:
  - GET_ID_BYTE: CAPTURE, storing nm_data_out into id_out byte k.
  - GET_DATA_PAGE_BYTE: STREAM.
  - Any other command: GAP.
- STREAM: byte_data=nm_data_out (registered), byte_valid=1, held until byte_ready=1. byte_data must not change while valid && !ready. The transfer completes on the valid&&ready cycle. Backpressure stalls the sequencer indefinitely, with no timeout.
- GAP: GAP_CYCLES idle cycles, then the next ISSUE, or FIN after the last command.
- FIN: done=1 for one cycle; id_valid=1 if op=0; seq_busy drops the same cycle.
- ERR: error=1 for one cycle, nm_activate stays 0, return to IDLE. Partial id_out is kept, and id_valid stays 0.
- Counters: byte counter is 16 bit and ends at PAGE_BYTES-1 with no wrap; ID index is 3 bit.
- Boundary cases:
  - start while seq_busy is ignored.
  - start and reset in the same cycle: reset wins.
  - Async reset mid-sequence: nm_activate and byte_valid drop immediately, and no further command is issued.
  - nm_busy=0 during ARM is legal: WAIT exits on its first cycle.

Test Plan:
1. op=0, ce_sel=0x00, model returns ID 2C E5 FF 03 86 -> cmd order 01,0E,04,06,13×5; id_out[39:0]=0x8603FFE52C; id_valid=1; one done pulse.
2. op=1, PAGE_BYTES=4 (override), model bytes A0..A3, byte_ready=1 -> cmds 12,09,12,15×4; stream A0,A1,A2,A3; done.
3. Same as 2 with byte_ready low 5 cycles on byte 2 -> byte_data=A2 held stable; no extra 0x15 issued until the handshake; order preserved.
4. nm_busy stuck high after M_NAND_RESET, TIMEOUT=50 -> error pulse about 50 cycles after ARM; no further activate; seq_busy=0; id_valid=0.
5. Assert reset during the 3rd GET_ID_BYTE wait -> all outputs 0 immediately; a new start then runs the full probe cleanly.
6. Second start pulse while seq_busy=1 -> ignored; exactly one done pulse, with the command count unchanged.

Source files
------------

// File: rtl/nand_cmd_sequencer.sv
// nand_cmd_sequencer
//   Host-side command sequencer that sits in front of nand_master. One start
//   pulse produces the whole command / activate / busy-wait script for either
//   an init + ID probe (op=0) or a page read streamed out byte by byte (op=1).
//
// Ports
//   clk, reset          : system clock; asynchronous active-high reset
//   start, op, ce_sel   : request pulse, operation select, chip-enable value
//   id_out, id_valid    : captured ID bytes (byte k in [8k+7:8k]) and flag
//   byte_data/valid/ready : page byte stream with valid/ready handshake
//   seq_busy, done, error : sequence status; done/error are one-cycle pulses
//   nm_cmd_in, nm_activate, nm_data_in : command interface to nand_master
//   nm_data_out, nm_busy               : response from nand_master
module nand_cmd_sequencer #(
  parameter int PAGE_BYTES = 4320,
  parameter int ID_BYTES   = 5,
  parameter int TIMEOUT    = 1000000,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [7:0]  ce_sel,
  output logic [63:0] id_out,
  output logic        id_valid,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        seq_busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  nm_cmd_in,
  output logic        nm_activate,
  output logic [7:0]  nm_data_in,
  input  logic [7:0]  nm_data_out,
  input  logic        nm_busy
);

  localparam logic [5:0] M_RESET               = 6'h01;
  localparam logic [5:0] M_NAND_RESET          = 6'h04;
  localparam logic [5:0] M_NAND_READ_ID        = 6'h06;
  localparam logic [5:0] M_NAND_READ           = 6'h09;
  localparam logic [5:0] MI_CHIP_ENABLE        = 6'h0E;
  localparam logic [5:0] MI_RESET_INDEX        = 6'h12;
  localparam logic [5:0] MI_GET_ID_BYTE        = 6'h13;
  localparam logic [5:0] MI_GET_DATA_PAGE_BYTE = 6'h15;

  localparam logic [15:0] LAST_BYTE = 16'(PAGE_BYTES - 1);
  localparam logic [2:0]  LAST_ID   = 3'(ID_BYTES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [4:0]  GAP_LEN   = 5'(GAP_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_CAPTURE, S_STREAM, S_GAP, S_FIN, S_ERR
  } state_t;

  state_t       state_q;
  logic         op_q;
  logic [7:0]   ce_q;
  logic [2:0]   step_q;
  logic [2:0]   id_idx_q;
  logic [15:0]  byte_cnt_q;
  logic [31:0]  tmo_q;
  logic [3:0]   gap_q;
  logic         last_q;
  logic [63:0]  id_q;
  logic         id_valid_q;
  logic [7:0]   byte_data_q;
  logic         byte_valid_q;
  logic         seq_busy_q;
  logic         done_q;
  logic         error_q;
  logic [5:0]   cmd_q;
  logic [7:0]   data_q;
  logic         act_q;

  logic [2:0]   step_d;
  logic [13:0]  next_cmd_d;
  logic         last_d;
  logic         gap_done;

  // Script step -> {command, data_in}. Steps below the loop stage are the
  // fixed preamble; the loop stage repeats the per-byte fetch command.
  function automatic logic [13:0] script(input logic o, input logic [2:0] s,
                                         input logic [7:0] ce);
    logic [13:0] r;
    r = {MI_GET_ID_BYTE, 8'h00};
    if (!o) begin
      case (s)
        3'd0:    r = {M_RESET, 8'h00};
        3'd1:    r = {MI_CHIP_ENABLE, ce};
        3'd2:    r = {M_NAND_RESET, 8'h00};
        3'd3:    r = {M_NAND_READ_ID, 8'h00};
        default: r = {MI_GET_ID_BYTE, 8'h00};
      endcase
    end else begin
      case (s)
        3'd0:    r = {MI_RESET_INDEX, 8'h00};
        3'd1:    r = {M_NAND_READ, 8'h00};
        3'd2:    r = {MI_RESET_INDEX, 8'h00};
        default: r = {MI_GET_DATA_PAGE_BYTE, 8'h00};
      endcase
    end
    return r;
  endfunction

  // Command to issue when leaving GAP. The step counter saturates at the loop
  // stage (4 for the probe, 3 for the page read); inside the loop the byte/ID
  // counters decide whether this is the final command of the script.
  always_comb begin
    step_d = step_q;
    if ((!op_q && step_q < 3'd4) || (op_q && step_q < 3'd3)) step_d = step_q + 3'd1;
    next_cmd_d = script(op_q, step_d, ce_q);
    last_d = op_q ? (step_d == 3'd3 && byte_cnt_q == LAST_BYTE)
                  : (step_d == 3'd4 && id_idx_q == LAST_ID);
  end

  // GAP always occupies at least one cycle, so GAP_CYCLES of 0 and 1 behave alike.
  assign gap_done = ({1'b0, gap_q} + 5'd1) >= GAP_LEN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= 1'b0;
      ce_q         <= 8'h00;
      step_q       <= 3'd0;
      id_idx_q     <= 3'd0;
      byte_cnt_q   <= 16'd0;
      tmo_q        <= 32'd0;
      gap_q        <= 4'd0;
      last_q       <= 1'b0;
      id_q         <= 64'd0;
      id_valid_q   <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      seq_busy_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cmd_q        <= 6'd0;
      data_q       <= 8'h00;
      act_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q       <= op;
            ce_q       <= ce_sel;
            id_q       <= 64'd0;
            id_valid_q <= 1'b0;
            step_q     <= 3'd0;
            id_idx_q   <= 3'd0;
            byte_cnt_q <= 16'd0;
            last_q     <= 1'b0;
            seq_busy_q <= 1'b1;
            {cmd_q, data_q} <= script(op, 3'd0, ce_sel);
            act_q      <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        // activate is registered on entry so it is high exactly during ISSUE
        S_ISSUE: begin
          act_q   <= 1'b0;
          state_q <= S_ARM;
        end
        // the master raises busy a cycle after activate; do not look yet
        S_ARM: begin
          tmo_q   <= 32'd0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!nm_busy) begin
            gap_q <= 4'd0;
            if (cmd_q == MI_GET_ID_BYTE) begin
              state_q <= S_CAPTURE;
            end else if (cmd_q == MI_GET_DATA_PAGE_BYTE) begin
              byte_data_q  <= nm_data_out;
              byte_valid_q <= 1'b1;
              state_q      <= S_STREAM;
            end else begin
              state_q <= S_GAP;
            end
          end else if (tmo_q == TMO_LAST) begin
            error_q    <= 1'b1;
            seq_busy_q <= 1'b0;
            state_q    <= S_ERR;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        S_CAPTURE: begin
          id_q[{id_idx_q, 3'b000} +: 8] <= nm_data_out;
          if (!last_q) id_idx_q <= id_idx_q + 3'd1;
          state_q <= S_GAP;
        end
        // byte_data_q is frozen until the handshake; no timeout on backpressure
        S_STREAM: begin
          if (byte_ready) begin
            byte_valid_q <= 1'b0;
            if (!last_q) byte_cnt_q <= byte_cnt_q + 16'd1;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_done) begin
            if (last_q) begin
              done_q     <= 1'b1;
              id_valid_q <= !op_q;
              seq_busy_q <= 1'b0;
              state_q    <= S_FIN;
            end else begin
              step_q          <= step_d;
              last_q          <= last_d;
              {cmd_q, data_q} <= next_cmd_d;
              act_q           <= 1'b1;
              state_q         <= S_ISSUE;
            end
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          error_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign id_out      = id_q;
  assign id_valid    = id_valid_q;
  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign seq_busy    = seq_busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign nm_cmd_in   = cmd_q;
  assign nm_activate = act_q;
  assign nm_data_in  = data_q;

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
module tb_nand_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [7:0]  ce_sel;
  logic [63:0] id_out;
  logic        id_valid;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        seq_busy;
  logic        done;
  logic        error;
  logic [5:0]  nm_cmd_in;
  logic        nm_activate;
  logic [7:0]  nm_data_in;
  logic [7:0]  nm_data_out;
  logic        nm_busy;

  nand_cmd_sequencer #(
    .PAGE_BYTES(4), .ID_BYTES(5), .TIMEOUT(50), .GAP_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .ce_sel(ce_sel),
    .id_out(id_out), .id_valid(id_valid), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .seq_busy(seq_busy),
    .done(done), .error(error), .nm_cmd_in(nm_cmd_in),
    .nm_activate(nm_activate), .nm_data_in(nm_data_in),
    .nm_data_out(nm_data_out), .nm_busy(nm_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- nand_master responder model ----------------
  logic [7:0] id_tab   [0:4] = '{8'h2C, 8'hE5, 8'hFF, 8'h03, 8'h86};
  logic [7:0] page_tab [0:3] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
  logic       stuck = 1'b0;
  logic [5:0] mcmd;
  int         mcnt, mk, pk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      nm_busy     <= 1'b0;
      nm_data_out <= 8'h00;
      mcnt        <= 0;
      mk          <= 0;
      pk          <= 0;
      mcmd        <= 6'd0;
    end else if (nm_activate) begin
      mcmd    <= nm_cmd_in;
      nm_busy <= 1'b1;
      mcnt    <= 3;
      if (nm_cmd_in == 6'h06) mk <= 0;
      if (nm_cmd_in == 6'h12) pk <= 0;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        if (!(stuck && mcmd == 6'h04)) nm_busy <= 1'b0;
        if (mcmd == 6'h13) begin
          nm_data_out <= id_tab[mk % 5];
          mk <= mk + 1;
        end else if (mcmd == 6'h15) begin
          nm_data_out <= page_tab[pk % 4];
          pk <= pk + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [5:0] c;
    logic [7:0] d;
    logic       chkd;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_b[$];

  int  cyc = 0, act_cnt = 0, done_cnt = 0, err_cnt = 0, st_cnt = 0, last_act_cyc = 0;
  logic       held = 1'b0;
  logic [7:0] held_data = 8'h00;

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] b;
    cyc++;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (done)  done_cnt++;
      if (error) err_cnt++;
      if (nm_activate) begin
        act_cnt++;
        last_act_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd: got 0x%0h expected no command", nm_cmd_in);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_order", {58'd0, nm_cmd_in}, {58'd0, e.c});
          if (e.chkd) chk("cmd_data", {56'd0, nm_data_in}, {56'd0, e.d});
        end
      end
      if (byte_valid) begin
        if (held) chk("byte_stable", {56'd0, byte_data}, {56'd0, held_data});
        if (byte_ready) begin
          st_cnt++;
          held = 1'b0;
          if (exp_b.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got 0x%0h expected no byte", byte_data);
          end else begin
            b = exp_b.pop_front();
            chk("stream_byte", {56'd0, byte_data}, {56'd0, b});
          end
        end else begin
          held = 1'b1;
          held_data = byte_data;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_cmd(input logic [5:0] c, input logic [7:0] d, input logic k);
    exp_t e;
    e.c = c; e.d = d; e.chkd = k;
    exp_q.push_back(e);
  endtask

  task automatic push_probe(input logic [7:0] ce);
    push_cmd(6'h01, 8'h00, 1'b0);
    push_cmd(6'h0E, ce,    1'b1);
    push_cmd(6'h04, 8'h00, 1'b0);
    push_cmd(6'h06, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) push_cmd(6'h13, 8'h00, 1'b0);
  endtask

  task automatic push_read();
    push_cmd(6'h12, 8'h00, 1'b0);
    push_cmd(6'h09, 8'h00, 1'b0);
    push_cmd(6'h12, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) push_cmd(6'h15, 8'h00, 1'b0);
    exp_b.push_back(8'hA0);
    exp_b.push_back(8'hA1);
    exp_b.push_back(8'hA2);
    exp_b.push_back(8'hA3);
  endtask

  task automatic do_start(input logic o, input logic [7:0] ce);
    @(posedge clk); #1;
    start = 1'b1; op = o; ce_sel = ce;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int d0, e0, n;
    d0 = done_cnt; e0 = err_cnt; n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL end_timeout: got no done/error after %0d cycles, expected one", budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  int d0, e0, a0, s0, a1, n, lat;

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; ce_sel = 8'h00; byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_activate", {63'd0, nm_activate}, 64'd0);
    chk("rst_cmd",      {58'd0, nm_cmd_in}, 64'd0);
    chk("rst_status",   {60'd0, seq_busy, done, error, id_valid}, 64'd0);
    chk("rst_id_out",   id_out, 64'd0);
    chk("rst_stream",   {55'd0, byte_valid, byte_data}, 64'd0);
    reset = 1'b0;

    // 1: ID probe
    d0 = done_cnt; e0 = err_cnt;
    push_probe(8'h00);
    do_start(1'b0, 8'h00);
    wait_end(600);
    chk("t1_done",     64'(done_cnt - d0), 64'd1);
    chk("t1_error",    64'(err_cnt - e0), 64'd0);
    chk("t1_id_out",   id_out, 64'h0000_0086_03FF_E52C);
    chk("t1_id_valid", {63'd0, id_valid}, 64'd1);
    chk("t1_seq_busy", {63'd0, seq_busy}, 64'd0);
    chk("t1_q_empty",  64'(exp_q.size()), 64'd0);

    // 2: page read, ready always high
    d0 = done_cnt; s0 = st_cnt;
    push_read();
    do_start(1'b1, 8'h00);
    wait_end(600);
    chk("t2_done",     64'(done_cnt - d0), 64'd1);
    chk("t2_bytes",    64'(st_cnt - s0), 64'd4);
    chk("t2_id_clear", {id_out[62:0], id_valid}, 64'd0);
    chk("t2_q_empty",  64'(exp_q.size() + exp_b.size()), 64'd0);

    // 3: page read with backpressure on byte 2
    d0 = done_cnt; s0 = st_cnt;
    push_read();
    do_start(1'b1, 8'h00);
    n = 0;
    while (st_cnt - s0 < 2 && n < 400) begin @(posedge clk); n++; end
    #1 byte_ready = 1'b0;
    n = 0;
    while (!byte_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("t3_stall_valid", {63'd0, byte_valid}, 64'd1);
    a0 = act_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("t3_stall_data", {56'd0, byte_data}, 64'hA2);
    chk("t3_no_cmd_in_stall", 64'(act_cnt - a0), 64'd0);
    byte_ready = 1'b1;
    wait_end(600);
    chk("t3_done",    64'(done_cnt - d0), 64'd1);
    chk("t3_bytes",   64'(st_cnt - s0), 64'd4);
    chk("t3_q_empty", 64'(exp_q.size() + exp_b.size()), 64'd0);

    // 4: busy stuck after M_NAND_RESET -> timeout
    stuck = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    push_cmd(6'h01, 8'h00, 1'b0);
    push_cmd(6'h0E, 8'h5A, 1'b1);
    push_cmd(6'h04, 8'h00, 1'b0);
    do_start(1'b0, 8'h5A);
    wait_end(400);
    lat = cyc - last_act_cyc;
    chk("t4_error",    64'(err_cnt - e0), 64'd1);
    chk("t4_done",     64'(done_cnt - d0), 64'd0);
    chk("t4_latency_in_range", {63'd0, (lat >= 48 && lat <= 60)}, 64'd1);
    chk("t4_status",   {62'd0, seq_busy, id_valid}, 64'd0);
    chk("t4_q_empty",  64'(exp_q.size()), 64'd0);
    a0 = act_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("t4_no_more_cmd", 64'(act_cnt - a0), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stuck = 1'b0;

    // 5: reset during the third GET_ID_BYTE wait, then a clean probe
    push_probe(8'h33);
    a0 = act_cnt;
    do_start(1'b0, 8'h33);
    n = 0;
    while (act_cnt - a0 < 7 && n < 400) begin @(posedge clk); n++; end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b1;
    #1;
    chk("t5_rst_activate", {63'd0, nm_activate}, 64'd0);
    chk("t5_rst_status",   {60'd0, seq_busy, done, error, id_valid}, 64'd0);
    chk("t5_rst_outputs",  {id_out[47:0], byte_valid, byte_data, 1'b0, nm_cmd_in} & 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    a1 = act_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_start_with_reset_ignored", {63'd0, seq_busy}, 64'd0);
    chk("t5_no_cmd_after_reset", 64'(act_cnt - a1), 64'd0);
    d0 = done_cnt;
    push_probe(8'h33);
    do_start(1'b0, 8'h33);
    wait_end(600);
    chk("t5_done",     64'(done_cnt - d0), 64'd1);
    chk("t5_id_out",   id_out, 64'h0000_0086_03FF_E52C);
    chk("t5_id_valid", {63'd0, id_valid}, 64'd1);

    // 6: second start while busy is ignored
    d0 = done_cnt; a0 = act_cnt;
    push_probe(8'h77);
    do_start(1'b0, 8'h77);
    repeat (10) @(posedge clk);
    do_start(1'b1, 8'h11);
    wait_end(600);
    repeat (40) @(posedge clk);
    #1;
    chk("t6_done",      64'(done_cnt - d0), 64'd1);
    chk("t6_cmd_count", 64'(act_cnt - a0), 64'd9);
    chk("t6_q_empty",   64'(exp_q.size()), 64'd0);
    chk("t6_id_out",    id_out, 64'h0000_0086_03FF_E52C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
